// File: rtl/game_sequencer.sv
// Tic-tac-toe game sequencer: alternates user (O) and engine (X) moves.
// Optional move counter output enabled by defining MOVE_COUNT_EN.
module game_sequencer #(
  parameter int USER_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic [8:0] user_move,
  input  logic       user_valid,
  output logic       user_ready,
  input  logic [8:0] ai_move,
  output logic [8:0] x_board,
  output logic [8:0] o_board,
  output logic       illegal_move,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       ai_fault
`ifdef MOVE_COUNT_EN
  ,
  output logic [3:0] move_cnt
`endif
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] USER_WAIT = 3'd1;
  localparam logic [2:0] USER_CHK  = 3'd2;
  localparam logic [2:0] AI_MOVE   = 3'd3;
  localparam logic [2:0] AI_CHK    = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [2:0] START =
    (USER_FIRST != 0) ? USER_WAIT : AI_MOVE;

  logic [2:0] state;
  logic [8:0] occ;
  logic       full;
  logic       user_ok;
  logic       ai_ok;
  logic       user_wr;
  logic       ai_wr;

  function automatic logic onehot9(input logic [8:0] m);
    return (m != 9'd0) && ((m & (m - 9'd1)) == 9'd0);
  endfunction

  // bit 8 is top-left, row-major
  function automatic logic line3(input logic [8:0] b);
    return (&b[8:6]) | (&b[5:3]) | (&b[2:0]) |
           (b[8] & b[5] & b[2]) |
           (b[7] & b[4] & b[1]) |
           (b[6] & b[3] & b[0]) |
           (b[8] & b[4] & b[0]) |
           (b[6] & b[4] & b[2]);
  endfunction

  always_comb begin
    occ        = x_board | o_board;
    full       = &occ;
    user_ready = (state == USER_WAIT);
    user_ok    = onehot9(user_move) &&
                 ((user_move & occ) == 9'd0);
    ai_ok      = onehot9(ai_move) &&
                 ((ai_move & occ) == 9'd0);
    user_wr    = user_ready && user_valid && user_ok;
    ai_wr      = (state == AI_MOVE) && ai_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x_board      <= 9'd0;
      o_board      <= 9'd0;
      illegal_move <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
      ai_fault     <= 1'b0;
    end else if (new_game) begin
      state        <= START;
      x_board      <= 9'd0;
      o_board      <= 9'd0;
      illegal_move <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
      ai_fault     <= 1'b0;
    end else begin
      illegal_move <= 1'b0;
      unique case (1'b1)
        (state == USER_WAIT): begin
          if (user_valid) begin
            if (user_ok) begin
              o_board <= o_board | user_move;
              state   <= USER_CHK;
            end else begin
              illegal_move <= 1'b1;
            end
          end
        end
        (state == USER_CHK): begin
          if (line3(o_board)) begin
            state     <= DONE;
            winner    <= 2'b10;
            game_over <= 1'b1;
          end else if (full) begin
            state     <= DONE;
            winner    <= 2'b11;
            game_over <= 1'b1;
          end else begin
            state <= AI_MOVE;
          end
        end
        (state == AI_MOVE): begin
          if (ai_ok) begin
            x_board <= x_board | ai_move;
            state   <= AI_CHK;
          end else begin
            ai_fault  <= 1'b1;
            winner    <= 2'b00;
            game_over <= 1'b1;
            state     <= DONE;
          end
        end
        (state == AI_CHK): begin
          if (line3(x_board)) begin
            state     <= DONE;
            winner    <= 2'b01;
            game_over <= 1'b1;
          end else if (full) begin
            state     <= DONE;
            winner    <= 2'b11;
            game_over <= 1'b1;
          end else begin
            state <= USER_WAIT;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MOVE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_cnt <= 4'd0;
    end else if (new_game) begin
      move_cnt <= 4'd0;
    end else if ((user_wr || ai_wr) && move_cnt != 4'd9) begin
      move_cnt <= move_cnt + 4'd1;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = user_wr ^ ai_wr;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: vector table plus hand sequences.
// Define MOVE_COUNT_EN to also check the move counter.
module tb_game_sequencer;

  logic       clk;
  logic       rst_n;
  logic       new_game;
  logic [8:0] user_move;
  logic       user_valid;
  logic       user_ready;
  logic [8:0] ai_move;
  logic [8:0] x_board;
  logic [8:0] o_board;
  logic       illegal_move;
  logic       game_over;
  logic [1:0] winner;
  logic       ai_fault;
`ifdef MOVE_COUNT_EN
  logic [3:0] move_cnt;
`endif

  int checks;
  int errors;

  game_sequencer #(.USER_FIRST(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .new_game(new_game),
    .user_move(user_move),
    .user_valid(user_valid),
    .user_ready(user_ready),
    .ai_move(ai_move),
    .x_board(x_board),
    .o_board(o_board),
    .illegal_move(illegal_move),
    .game_over(game_over),
    .winner(winner),
    .ai_fault(ai_fault)
`ifdef MOVE_COUNT_EN
    ,
    .move_cnt(move_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ng;
    logic       uv;
    logic [8:0] um;
    logic [8:0] ai;
    logic [8:0] ex;
    logic [8:0] eo;
    logic       rdy;
    logic       ill;
    logic       go;
    logic [1:0] w;
    logic       flt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic ng, logic uv, logic [8:0] um, logic [8:0] ai,
    logic [8:0] ex, logic [8:0] eo, logic rdy, logic ill,
    logic go, logic [1:0] w, logic flt);
    vec_t v;
    v.ng = ng; v.uv = uv; v.um = um; v.ai = ai;
    v.ex = ex; v.eo = eo; v.rdy = rdy; v.ill = ill;
    v.go = go; v.w = w; v.flt = flt;
    return v;
  endfunction

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic chk_all(string n, logic [8:0] ex,
    logic [8:0] eo, logic rdy, logic ill, logic go,
    logic [1:0] w, logic flt);
    chk({n, ".x"}, int'(x_board), int'(ex));
    chk({n, ".o"}, int'(o_board), int'(eo));
    chk({n, ".rdy"}, int'(user_ready), int'(rdy));
    chk({n, ".ill"}, int'(illegal_move), int'(ill));
    chk({n, ".go"}, int'(game_over), int'(go));
    chk({n, ".win"}, int'(winner), int'(w));
    chk({n, ".flt"}, int'(ai_fault), int'(flt));
  endtask

  task automatic step(logic ng, logic uv,
    logic [8:0] um, logic [8:0] ai);
    new_game   = ng;
    user_valid = uv;
    user_move  = um;
    ai_move    = ai;
    @(posedge clk);
    #1;
  endtask

  logic [8:0] seq [9];
  logic [8:0] ex;
  logic [8:0] eo;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    new_game = 1'b0;
    user_valid = 1'b0;
    user_move = 9'd0;
    ai_move = 9'd0;

    // REQ-031 win for O
    tv.push_back(mk(1,0,9'h000,9'h000, 9'h000,9'h000, 1,0,0,2'd0,0));
    tv.push_back(mk(0,1,9'h100,9'h000, 9'h000,9'h100, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h000,9'h100, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h010, 9'h010,9'h100, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h010,9'h100, 1,0,0,2'd0,0));
    tv.push_back(mk(0,1,9'h080,9'h000, 9'h010,9'h180, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h010,9'h180, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h001, 9'h011,9'h180, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h011,9'h180, 1,0,0,2'd0,0));
    tv.push_back(mk(0,1,9'h040,9'h000, 9'h011,9'h1C0, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h011,9'h1C0, 0,0,1,2'd2,0));
    tv.push_back(mk(0,1,9'h002,9'h000, 9'h011,9'h1C0, 0,0,1,2'd2,0));
    // REQ-032 illegal moves
    tv.push_back(mk(1,0,9'h000,9'h000, 9'h000,9'h000, 1,0,0,2'd0,0));
    tv.push_back(mk(0,1,9'h100,9'h000, 9'h000,9'h100, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h000,9'h100, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h010, 9'h010,9'h100, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h010,9'h100, 1,0,0,2'd0,0));
    tv.push_back(mk(0,1,9'h010,9'h000, 9'h010,9'h100, 1,1,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h010,9'h100, 1,0,0,2'd0,0));
    tv.push_back(mk(0,1,9'h003,9'h000, 9'h010,9'h100, 1,1,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h010,9'h100, 1,0,0,2'd0,0));
    // REQ-033 engine faults: empty move, then occupied square
    tv.push_back(mk(0,1,9'h001,9'h000, 9'h010,9'h101, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h010,9'h101, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h010,9'h101, 0,0,1,2'd0,1));
    tv.push_back(mk(1,0,9'h000,9'h000, 9'h000,9'h000, 1,0,0,2'd0,0));
    tv.push_back(mk(0,1,9'h100,9'h000, 9'h000,9'h100, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h000,9'h100, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h100, 9'h000,9'h100, 0,0,1,2'd0,1));
    // new_game beats a same-cycle user move
    tv.push_back(mk(1,1,9'h001,9'h000, 9'h000,9'h000, 1,0,0,2'd0,0));
    // X wins middle row
    tv.push_back(mk(0,1,9'h100,9'h000, 9'h000,9'h100, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h000,9'h100, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h010, 9'h010,9'h100, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h010,9'h100, 1,0,0,2'd0,0));
    tv.push_back(mk(0,1,9'h080,9'h000, 9'h010,9'h180, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h010,9'h180, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h020, 9'h030,9'h180, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h030,9'h180, 1,0,0,2'd0,0));
    tv.push_back(mk(0,1,9'h001,9'h000, 9'h030,9'h181, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h030,9'h181, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h008, 9'h038,9'h181, 0,0,0,2'd0,0));
    tv.push_back(mk(0,0,9'h000,9'h000, 9'h038,9'h181, 0,0,1,2'd1,0));

    #12;
    chk_all("reset", 9'h0, 9'h0, 0, 0, 0, 2'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 9'h100, 9'h000);
    chk_all("idle", 9'h0, 9'h0, 0, 0, 0, 2'd0, 0);

    foreach (tv[i]) begin
      step(tv[i].ng, tv[i].uv, tv[i].um, tv[i].ai);
      chk_all($sformatf("v%0d", i), tv[i].ex, tv[i].eo,
        tv[i].rdy, tv[i].ill, tv[i].go, tv[i].w, tv[i].flt);
    end
`ifdef MOVE_COUNT_EN
    chk("cnt_xwin", int'(move_cnt), 6);
`endif

    // draw: O X O / O X X / X O O
    seq[0] = 9'h100; seq[1] = 9'h080; seq[2] = 9'h040;
    seq[3] = 9'h010; seq[4] = 9'h020; seq[5] = 9'h008;
    seq[6] = 9'h002; seq[7] = 9'h004; seq[8] = 9'h001;
    step(1, 0, 9'h0, 9'h0);
    ex = 9'h0;
    eo = 9'h0;
`ifdef MOVE_COUNT_EN
    chk("cnt_clr", int'(move_cnt), 0);
`endif
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) begin
        step(0, 1, seq[i], 9'h0);
        eo = eo | seq[i];
        chk_all($sformatf("d%0du", i), ex, eo, 0, 0, 0, 2'd0, 0);
        step(0, 0, 9'h0, 9'h0);
        if (i == 8)
          chk_all("draw", ex, eo, 0, 0, 1, 2'd3, 0);
        else
          chk_all($sformatf("d%0dc", i), ex, eo, 0, 0, 0, 2'd0, 0);
      end else begin
        step(0, 0, 9'h0, seq[i]);
        ex = ex | seq[i];
        step(0, 0, 9'h0, 9'h0);
        chk_all($sformatf("d%0da", i), ex, eo, 1, 0, 0, 2'd0, 0);
      end
    end
    chk("draw_full", int'(ex | eo), 'h1FF);
`ifdef MOVE_COUNT_EN
    chk("cnt_draw", int'(move_cnt), 9);
`endif

    // REQ-035 async reset mid-game
    step(1, 0, 9'h0, 9'h0);
    step(0, 1, 9'h100, 9'h0);
    step(0, 0, 9'h0, 9'h0);
    step(0, 0, 9'h0, 9'h010);
    step(0, 0, 9'h0, 9'h0);
    step(0, 1, 9'h080, 9'h0);
    chk_all("pre_rst", 9'h010, 9'h180, 0, 0, 0, 2'd0, 0);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 9'h0, 9'h0, 0, 0, 0, 2'd0, 0);
`ifdef MOVE_COUNT_EN
    chk("cnt_rst", int'(move_cnt), 0);
`endif
    step(0, 1, 9'h100, 9'h0);
    chk_all("in_rst", 9'h0, 9'h0, 0, 0, 0, 2'd0, 0);
    #2;
    rst_n = 1'b1;
    step(0, 1, 9'h100, 9'h0);
    chk_all("post_rst", 9'h0, 9'h0, 0, 0, 0, 2'd0, 0);
    step(1, 1, 9'h001, 9'h0);
    chk_all("ng_uv", 9'h0, 9'h0, 1, 0, 0, 2'd0, 0);
    step(0, 1, 9'h001, 9'h0);
    chk_all("after_ng", 9'h0, 9'h001, 0, 0, 0, 2'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
